// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 16x16 general-purpose register file.
package reg_file_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int NUM_REGS       = 16;
  localparam int REG_IDX_W      = 4;

  typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]       reg_onehot_t;

  // OR of the indices of all set bits; exact only for a one-hot input.
  function automatic logic [REG_IDX_W-1:0] onehot_to_idx(input reg_onehot_t oh);
    logic [REG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (oh[i]) idx = idx | REG_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_file_16x16_onehot_check.sv
// Classifies a 16-bit write enable as zero / one-hot / multi-hot and encodes its index.
module onehot_check
  import reg_file_pkg::*;
(
  input  reg_onehot_t          vec_i,
  output logic                 is_zero_o,
  output logic                 is_onehot_o,
  output logic                 is_multi_o,
  output logic [REG_IDX_W-1:0] idx_o
);

  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  logic lowCleared;

  assign lowCleared  = ((vec_i & (vec_i - reg_onehot_t'(1))) == '0);
  assign is_zero_o   = (vec_i == '0);
  assign is_onehot_o = !is_zero_o && lowCleared;
  assign is_multi_o  = !is_zero_o && !lowCleared;
  assign idx_o       = onehot_to_idx(vec_i);

endmodule

// File: rtl/reg_file_16x16.sv
// 16-entry register file with two registered read ports, sticky malformed-enable flag
// and saturating write counter. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module reg_file_16x16
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [15:0]       wr_en_onehot,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_a_sel,
  input  logic [3:0]        rd_b_sel,
  input  logic              rd_stall,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              wr_err,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic [DATA_W-1:0]    rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                 wr_err_q, wr_err_d;
  logic [15:0]          wr_count_q, wr_count_d;

  logic                 isZero, isOnehot, isMulti;
  logic [REG_IDX_W-1:0] wrIdx;
  logic                 wrAttempt, wrAccept, wrMalformed, wrCommit, r0Target;
  logic [DATA_W-1:0]    rdARaw, rdBRaw;

  onehot_check u_onehot_check (
    .vec_i       (wr_en_onehot),
    .is_zero_o   (isZero),
    .is_onehot_o (isOnehot),
    .is_multi_o  (isMulti),
    .idx_o       (wrIdx)
  );

  // An accepted write to a hardwired r0 still counts but never changes storage.
  assign wrAttempt   = wr_valid && !isZero;
  assign wrAccept    = wrAttempt && isOnehot;
  assign wrMalformed = wrAttempt && isMulti;
  assign r0Target    = (ZERO_R0 != 0) && (wrIdx == '0);
  assign wrCommit    = wrAccept && !r0Target;

  always_comb begin
    regs_d = regs_q;
    if (wrCommit) regs_d[wrIdx] = wr_data;
  end

  always_comb begin
    rdARaw = regs_q[rd_a_sel];
    rdBRaw = regs_q[rd_b_sel];
    if ((ZERO_R0 != 0) && (rd_a_sel == '0)) rdARaw = '0;
    if ((ZERO_R0 != 0) && (rd_b_sel == '0)) rdBRaw = '0;
`ifdef REGFILE_BYPASS_EN
    if (wrCommit && (wrIdx == rd_a_sel)) rdARaw = wr_data;
    if (wrCommit && (wrIdx == rd_b_sel)) rdBRaw = wr_data;
`endif
    rd_a_d = rd_stall ? rd_a_q : rdARaw;
    rd_b_d = rd_stall ? rd_b_q : rdBRaw;
  end

  always_comb begin
    wr_err_d   = wr_err_q || wrMalformed;
    wr_count_d = wr_count_q;
    if (wrAccept && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      wr_err_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      wr_err_q   <= wr_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_a_data = rd_a_q;
  assign rd_b_data = rd_b_q;
  assign wr_err    = wr_err_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_file_16x16.sv
// Scoreboard bench for reg_file_16x16: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them. Honors REGFILE_BYPASS_EN.
module tb_reg_file_16x16;

  localparam int K_RDA = 0;
  localparam int K_RDB = 1;
  localparam int K_ERR = 2;
  localparam int K_CNT = 3;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_en_onehot = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  rd_a_sel = '0;
  logic [3:0]  rd_b_sel = '0;
  logic        rd_stall = 1'b0;
  logic [15:0] rd_a_data, rd_b_data, wr_count;
  logic        wr_err;

  exp_t        sbQ[$];
  int          cycle = 0;
  int          nChecks = 0;
  int          nFail = 0;

  reg_file_16x16 #(.DATA_W(16), .ZERO_R0(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_en_onehot (wr_en_onehot),
    .wr_data      (wr_data),
    .rd_a_sel     (rd_a_sel),
    .rd_b_sel     (rd_b_sel),
    .rd_stall     (rd_stall),
    .rd_a_data    (rd_a_data),
    .rd_b_data    (rd_b_data),
    .wr_err       (wr_err),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [15:0] oh,
                               input logic [15:0] d, input logic [3:0] aSel,
                               input logic [3:0] bSel, input logic st);
    reset        = rst;
    wr_valid     = v;
    wr_en_onehot = oh;
    wr_data      = d;
    rd_a_sel     = aSel;
    rd_b_sel     = bSel;
    rd_stall     = st;
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the outputs produced by the edge just taken.
  task automatic checkOutput(input string name, input int kind, input logic [15:0] val);
    exp_t e;
    e.cyc  = cycle;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    sbQ.push_back(e);
  endtask

  // Pop every expectation that is due and compare it against the live DUT outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    while (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
      e = sbQ.pop_front();
      case (e.kind)
        K_RDA:   act = rd_a_data;
        K_RDB:   act = rd_b_data;
        K_ERR:   act = {15'd0, wr_err};
        default: act = wr_count;
      endcase
      nChecks++;
      if (act !== e.val) begin
        nFail++;
        $display("[TB] FAIL %s: actual %h required %h (cycle %0d)", e.name, act, e.val, cycle);
      end
    end
  end

  // Main stimulus sequence following the test plan.
  initial begin
    logic [15:0] hazardExp;
`ifdef REGFILE_BYPASS_EN
    hazardExp = 16'h5A5A;
`else
    hazardExp = 16'h0101;
`endif

    // Reset state
    applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    checkOutput("rst_rdA", K_RDA, 16'h0000);
    checkOutput("rst_rdB", K_RDB, 16'h0000);
    checkOutput("rst_err", K_ERR, 16'h0000);
    checkOutput("rst_cnt", K_CNT, 16'h0000);

    // Reset clears stored data
    applyStimulus(0, 1, 16'h0020, 16'hBEEF, 0, 0, 0);
    checkOutput("r5_cnt1", K_CNT, 16'h0001);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 5, 5, 0);
    checkOutput("r5_rdA", K_RDA, 16'hBEEF);
    checkOutput("r5_rdB", K_RDB, 16'hBEEF);
    applyStimulus(1, 1, 16'h0020, 16'h1111, 5, 5, 0);
    checkOutput("rst2_rdA", K_RDA, 16'h0000);
    checkOutput("rst2_cnt", K_CNT, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 5, 5, 0);
    checkOutput("r5clr_rdA", K_RDA, 16'h0000);
    checkOutput("r5clr_rdB", K_RDB, 16'h0000);
    checkOutput("r5clr_err", K_ERR, 16'h0000);
    checkOutput("r5clr_cnt", K_CNT, 16'h0000);

    // Basic write/read plus ignored enables
    applyStimulus(0, 1, 16'h0008, 16'h1234, 0, 0, 0);
    checkOutput("r3_cnt", K_CNT, 16'h0001);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 3, 3, 0);
    checkOutput("r3_rdA", K_RDA, 16'h1234);
    checkOutput("r3_rdB", K_RDB, 16'h1234);
    nChecks++;
    if (rd_a_data !== 16'h1234) begin
      nFail++;
      $display("[TB] FAIL direct_r3_rdA: actual %h required 1234", rd_a_data);
    end
    nChecks++;
    if (rd_b_data !== 16'h1234) begin
      nFail++;
      $display("[TB] FAIL direct_r3_rdB: actual %h required 1234", rd_b_data);
    end
    applyStimulus(0, 0, 16'h0018, 16'hFFFF, 3, 3, 0);
    checkOutput("novalid_err", K_ERR, 16'h0000);
    checkOutput("novalid_cnt", K_CNT, 16'h0001);
    applyStimulus(0, 1, 16'h0000, 16'hFFFF, 3, 3, 0);
    checkOutput("zeroen_err", K_ERR, 16'h0000);
    checkOutput("zeroen_cnt", K_CNT, 16'h0001);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 3, 3, 0);
    checkOutput("r3keep_rdA", K_RDA, 16'h1234);

    // Malformed enable
    applyStimulus(0, 1, 16'h0010, 16'h4444, 0, 0, 0);
    checkOutput("r4_cnt", K_CNT, 16'h0002);
    applyStimulus(0, 1, 16'h0018, 16'hFFFF, 0, 0, 0);
    checkOutput("multi_err", K_ERR, 16'h0001);
    checkOutput("multi_cnt", K_CNT, 16'h0002);
    nChecks++;
    if (wr_err !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL direct_multi_err: actual %b required 1", wr_err);
    end
    applyStimulus(0, 0, 16'h0000, 16'h0000, 3, 4, 0);
    checkOutput("multi_r3", K_RDA, 16'h1234);
    checkOutput("multi_r4", K_RDB, 16'h4444);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    checkOutput("sticky_err", K_ERR, 16'h0001);
    checkOutput("sticky_cnt", K_CNT, 16'h0002);
    nChecks++;
    if (wr_err !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL direct_sticky_err: actual %b required 1", wr_err);
    end
    applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    checkOutput("errclr", K_ERR, 16'h0000);

    // r0 hardwired to zero; write still counted, no forwarding
    applyStimulus(0, 1, 16'h0001, 16'hAAAA, 0, 0, 0);
    checkOutput("r0wr_rdA", K_RDA, 16'h0000);
    checkOutput("r0wr_cnt", K_CNT, 16'h0001);
    checkOutput("r0wr_err", K_ERR, 16'h0000);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    checkOutput("r0rd_rdA", K_RDA, 16'h0000);
    checkOutput("r0rd_rdB", K_RDB, 16'h0000);

    // Same-cycle hazard, then stall (writes continue during stall)
    applyStimulus(0, 1, 16'h0080, 16'h0101, 0, 0, 0);
    checkOutput("r7pre_cnt", K_CNT, 16'h0002);
    applyStimulus(0, 1, 16'h0080, 16'h5A5A, 7, 7, 0);
    checkOutput("hazard_rdA", K_RDA, hazardExp);
    checkOutput("hazard_rdB", K_RDB, hazardExp);
    checkOutput("hazard_cnt", K_CNT, 16'h0003);
    applyStimulus(0, 1, 16'h0004, 16'h2222, 3, 0, 1);
    checkOutput("stall1_rdA", K_RDA, hazardExp);
    checkOutput("stall1_rdB", K_RDB, hazardExp);
    checkOutput("stall1_cnt", K_CNT, 16'h0004);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 5, 1, 1);
    checkOutput("stall2_rdA", K_RDA, hazardExp);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 2, 2, 1);
    checkOutput("stall3_rdA", K_RDA, hazardExp);
    checkOutput("stall3_rdB", K_RDB, hazardExp);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 7, 2, 0);
    checkOutput("unstall_rdA", K_RDA, 16'h5A5A);
    checkOutput("unstall_rdB", K_RDB, 16'h2222);

    // Counter saturation
    applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 65534; i++) applyStimulus(0, 1, 16'h0002, i[15:0], 0, 0, 0);
    checkOutput("cnt_FFFE", K_CNT, 16'hFFFE);
    applyStimulus(0, 1, 16'h0002, 16'h0000, 0, 0, 0);
    checkOutput("cnt_FFFF", K_CNT, 16'hFFFF);
    applyStimulus(0, 1, 16'h0002, 16'h0000, 0, 0, 0);
    checkOutput("sat1_cnt", K_CNT, 16'hFFFF);
    applyStimulus(0, 1, 16'h0002, 16'h0000, 0, 0, 0);
    checkOutput("sat2_cnt", K_CNT, 16'hFFFF);
    nChecks++;
    if (wr_count !== 16'hFFFF) begin
      nFail++;
      $display("[TB] FAIL direct_sat_cnt: actual %h required FFFF", wr_count);
    end

    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    while (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      nChecks++;
      nFail++;
      $display("[TB] FAIL %s: never compared, required %h", e.name, e.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
